xnor_cim_array_ctrl: RTL and testbench

- Drives a ROWS x COLS array of XNOR SRAM bitcells from the other side of the bitcell interface.
- Writes weight rows through the WL/BL/BLb pins.
- Applies a binary input vector through the R_ctrl/R_ctrl_b pins, samples every cell's V_out, and reduces each column to an XNOR popcount, i.e. a binary dot product.
- Sits between the PE-group sequencer (valid/ready handshakes) and the bitcell array.

---
 rtl/xnor_cim_array_ctrl_pkg.sv | 34 +++
 rtl/xnor_cim_array_ctrl_if.sv | 34 +++
 rtl/xnor_col_popcount.sv | 20 ++
 rtl/xnor_cim_array_ctrl.sv | 168 ++++++++++++++++
 tb/tb_xnor_cim_array_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xnor_cim_array_ctrl_pkg.sv
// Shared types and width helpers for the XNOR compute-in-memory array controller.
// XNOR_CIM_SIGNED_OUT_EN widens each result slice by one bit for the signed form.
package xnor_cim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_REDUCE = 3'd4,
        ST_HOLD   = 3'd5
    } state_t;

    function automatic int cnt_width(input int rows);
        return $clog2(rows + 32'sd1);
    endfunction

    function automatic int row_width(input int rows);
        return (rows > 32'sd1) ? $clog2(rows) : 32'sd1;
    endfunction

    function automatic int slice_width(input int cnt_w);
`ifdef XNOR_CIM_SIGNED_OUT_EN
        return cnt_w + 32'sd1;
`else
        return cnt_w;
`endif
    endfunction

    function automatic int vout_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/xnor_cim_array_ctrl_if.sv
// Sequencer-side handshake bundle: weight write, compute request and result channels.
// Result slice width follows XNOR_CIM_SIGNED_OUT_EN through slice_width().
interface xnor_cim_array_ctrl_if
    import xnor_cim_pkg::*;
#(
    parameter int ROWS  = 16,
    parameter int COLS  = 8,
    parameter int CNT_W = cnt_width(ROWS)
);
    localparam int RW = row_width(ROWS);
    localparam int SW = slice_width(CNT_W);

    logic                 wr_valid;
    logic                 wr_ready;
    logic [RW-1:0]        wr_row;
    logic [COLS-1:0]      wr_data;
    logic                 cmp_valid;
    logic                 cmp_ready;
    logic [ROWS-1:0]      cmp_x;
    logic                 res_valid;
    logic                 res_ready;
    logic [COLS*SW-1:0]   res_data;

    modport master (
        output wr_valid, wr_row, wr_data, cmp_valid, cmp_x, res_ready,
        input  wr_ready, cmp_ready, res_valid, res_data
    );

    modport slave (
        input  wr_valid, wr_row, wr_data, cmp_valid, cmp_x, res_ready,
        output wr_ready, cmp_ready, res_valid, res_data
    );

endinterface

// File: rtl/xnor_col_popcount.sv
// Combinational population count of one sampled bitcell column.
module xnor_col_popcount
    import xnor_cim_pkg::*;
#(
    parameter int ROWS  = 16,
    parameter int CNT_W = cnt_width(ROWS)
) (
    input  logic [ROWS-1:0]  bits,
    output logic [CNT_W-1:0] count
);

    // Sum of set bits across the column
    always_comb begin
        count = '0;
        for (int r = 0; r < ROWS; r++) begin
            count = count + CNT_W'(bits[r]);
        end
    end

endmodule

// File: rtl/xnor_cim_array_ctrl.sv
// Controller for a ROWS x COLS XNOR SRAM array: row writes and binary dot products.
// Define XNOR_CIM_SIGNED_OUT_EN to report 2*popcount - ROWS per column instead of the popcount.
module xnor_cim_array_ctrl
    import xnor_cim_pkg::*;
#(
    parameter int ROWS  = 16,
    parameter int COLS  = 8,
    parameter int CNT_W = cnt_width(ROWS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    xnor_cim_array_ctrl_if.slave   bus,
    output logic [ROWS-1:0]        WL,
    output logic [COLS-1:0]        BL,
    output logic [COLS-1:0]        BLb,
    output logic [ROWS-1:0]        R_ctrl,
    output logic [ROWS-1:0]        R_ctrl_b,
    input  logic [ROWS*COLS-1:0]   V_out_arr
);
    localparam int SW = slice_width(CNT_W);
`ifdef XNOR_CIM_SIGNED_OUT_EN
    localparam logic [SW-1:0] ROWS_SW = SW'(ROWS);
`endif

    state_t               state_r;
    logic [ROWS-1:0]      wl_r;
    logic [ROWS-1:0]      wl_onehot_s;
    logic [COLS-1:0]      bl_r;
    logic [COLS-1:0]      blb_r;
    logic [ROWS-1:0]      rctrl_r;
    logic [ROWS-1:0]      rctrl_b_r;
    logic [ROWS*COLS-1:0] vout_q;
    logic [COLS*SW-1:0]   res_data_r;
    logic [COLS*SW-1:0]   res_pack_s;
    logic                 res_valid_r;
    logic                 wr_ready_r;
    logic                 cmp_ready_r;
    logic [CNT_W-1:0]     cnt_s [COLS];

    // Out-of-range row indices decode to an all-zero wordline
    always_comb begin
        wl_onehot_s = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (32'(bus.wr_row) == r) begin
                wl_onehot_s[r] = 1'b1;
            end else begin
                wl_onehot_s[r] = 1'b0;
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [ROWS-1:0] col_bits_s;

        // Gather column c from the row-major sampled array
        always_comb begin
            col_bits_s = '0;
            for (int r = 0; r < ROWS; r++) begin
                col_bits_s[r] = vout_q[vout_idx(r, c, COLS)];
            end
        end

        xnor_col_popcount #(.ROWS(ROWS), .CNT_W(CNT_W)) u_pop (
            .bits  (col_bits_s),
            .count (cnt_s[c])
        );
    end

    // Pack per-column counts into result slices
    always_comb begin
        res_pack_s = '0;
        for (int c = 0; c < COLS; c++) begin
`ifdef XNOR_CIM_SIGNED_OUT_EN
            res_pack_s[c*SW +: SW] = {cnt_s[c], 1'b0} - ROWS_SW;
`else
            res_pack_s[c*SW +: SW] = cnt_s[c];
`endif
        end
    end

    // Sequencer FSM with registered array pins and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            wl_r        <= '0;
            bl_r        <= '0;
            blb_r       <= '1;
            rctrl_r     <= '0;
            rctrl_b_r   <= '1;
            vout_q      <= '0;
            res_data_r  <= '0;
            res_valid_r <= 1'b0;
            wr_ready_r  <= 1'b1;
            cmp_ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.wr_valid) begin
                        state_r     <= ST_WRITE;
                        wl_r        <= wl_onehot_s;
                        bl_r        <= bus.wr_data;
                        blb_r       <= ~bus.wr_data;
                        wr_ready_r  <= 1'b0;
                        cmp_ready_r <= 1'b0;
                    end else if (bus.cmp_valid) begin
                        state_r     <= ST_DRIVE;
                        rctrl_r     <= bus.cmp_x;
                        rctrl_b_r   <= ~bus.cmp_x;
                        wr_ready_r  <= 1'b0;
                        cmp_ready_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state_r     <= ST_IDLE;
                    wl_r        <= '0;
                    wr_ready_r  <= 1'b1;
                    cmp_ready_r <= 1'b1;
                end
                ST_DRIVE: begin
                    state_r <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    vout_q  <= V_out_arr;
                    state_r <= ST_REDUCE;
                end
                ST_REDUCE: begin
                    res_data_r  <= res_pack_s;
                    res_valid_r <= 1'b1;
                    state_r     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_valid_r && bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        rctrl_r     <= '0;
                        rctrl_b_r   <= '1;
                        wr_ready_r  <= 1'b1;
                        cmp_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    wl_r        <= '0;
                    rctrl_r     <= '0;
                    rctrl_b_r   <= '1;
                    res_valid_r <= 1'b0;
                    wr_ready_r  <= 1'b1;
                    cmp_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign WL            = wl_r;
    assign BL            = bl_r;
    assign BLb           = blb_r;
    assign R_ctrl        = rctrl_r;
    assign R_ctrl_b      = rctrl_b_r;
    assign bus.wr_ready  = wr_ready_r;
    assign bus.cmp_ready = cmp_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;

endmodule

// File: tb/tb_xnor_cim_array_ctrl.sv
// Directed bench for xnor_cim_array_ctrl with behavioural bitcell arrays and an agreement-count model.
module tb_xnor_cim_array_ctrl;
    import xnor_cim_pkg::*;

    localparam int ROWS  = 16;
    localparam int COLS  = 8;
    localparam int CNT_W = cnt_width(ROWS);
    localparam int SW    = slice_width(CNT_W);
    localparam int RW    = row_width(ROWS);
    localparam int R2    = 12;

    logic clk = 1'b0;
    logic rst_n;
    logic arr_clr;
    always #5 clk = ~clk;

    xnor_cim_array_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
    xnor_cim_array_ctrl_if #(.ROWS(R2),   .COLS(COLS)) bus2 ();

    logic [ROWS-1:0]      wl, r_ctrl, r_ctrl_b;
    logic [COLS-1:0]      bl, blb;
    logic [ROWS*COLS-1:0] v_out;
    logic [COLS-1:0]      cells [ROWS];

    logic [R2-1:0]        wl2, r_ctrl2, r_ctrl_b2;
    logic [COLS-1:0]      bl2, blb2;
    logic [R2*COLS-1:0]   v_out2;
    logic [COLS-1:0]      cells2 [R2];

    xnor_cim_array_ctrl #(.ROWS(ROWS), .COLS(COLS)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .WL(wl), .BL(bl), .BLb(blb), .R_ctrl(r_ctrl), .R_ctrl_b(r_ctrl_b),
        .V_out_arr(v_out)
    );

    xnor_cim_array_ctrl #(.ROWS(R2), .COLS(COLS)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
        .WL(wl2), .BL(bl2), .BLb(blb2), .R_ctrl(r_ctrl2), .R_ctrl_b(r_ctrl_b2),
        .V_out_arr(v_out2)
    );

    // Bitcells latch BL while their wordline is high
    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (arr_clr) cells[r] <= '0;
            else if (wl[r]) cells[r] <= bl;
        end
        for (int r = 0; r < R2; r++) begin
            if (arr_clr) cells2[r] <= '0;
            else if (wl2[r]) cells2[r] <= bl2;
        end
    end

    // Cell output is XNOR of stored weight and row input, forced low while written
    always_comb begin
        v_out  = '0;
        v_out2 = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v_out[r*COLS+c] = wl[r] ? 1'b0 : ~(cells[r][c] ^ r_ctrl[r]);
        for (int r = 0; r < R2; r++)
            for (int c = 0; c < COLS; c++)
                v_out2[r*COLS+c] = wl2[r] ? 1'b0 : ~(cells2[r][c] ^ r_ctrl2[r]);
    end

    int                 n_vec;
    int                 n_err;
    logic [COLS-1:0]    wm [ROWS];
    logic [COLS*SW-1:0] exp_res;
    logic               exp_armed;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] to_slice(input int pc);
`ifdef XNOR_CIM_SIGNED_OUT_EN
        return SW'(2 * pc - ROWS);
`else
        return SW'(pc);
`endif
    endfunction

    // Column result = number of rows where stored weight equals input bit
    function automatic logic [COLS*SW-1:0] model_res(input logic [ROWS-1:0] x);
        logic [COLS*SW-1:0] res;
        res = '0;
        for (int c = 0; c < COLS; c++) begin
            int pc;
            pc = 0;
            for (int r = 0; r < ROWS; r++)
                if (wm[r][c] == x[r]) pc++;
            res[c*SW +: SW] = to_slice(pc);
        end
        return res;
    endfunction

    task automatic cycle_check();
        logic [COLS-1:0] nbl, nbl2;
        logic [ROWS-1:0] nrc;
        logic [R2-1:0]   nrc2;
        nbl = ~bl; nbl2 = ~bl2; nrc = ~r_ctrl; nrc2 = ~r_ctrl2;
        check("blb_inv", 64'(blb), 64'(nbl));
        check("rctrlb_inv", 64'(r_ctrl_b), 64'(nrc));
        check("blb_inv12", 64'(blb2), 64'(nbl2));
        check("rctrlb_inv12", 64'(r_ctrl_b2), 64'(nrc2));
        if (bus.res_valid) begin
            check("res_armed", 64'(exp_armed), 64'(1));
            check("res_data", 64'(bus.res_data), 64'(exp_res));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle_check();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(bus.wr_ready && bus.cmp_ready) && n < 20) begin
            tick();
            n++;
        end
        check("idle_wait", 64'({bus.wr_ready, bus.cmp_ready}), 64'(2'b11));
    endtask

    task automatic do_write(input int row, input logic [COLS-1:0] data);
        logic [ROWS-1:0] oh;
        oh = '0;
        oh[row] = 1'b1;
        wait_idle();
        bus.wr_valid = 1'b1;
        bus.wr_row   = RW'(row);
        bus.wr_data  = data;
        tick();
        bus.wr_valid = 1'b0;
        check("wr_wl", 64'(wl), 64'(oh));
        check("wr_bl", 64'(bl), 64'(data));
        check("wr_busy", 64'(bus.wr_ready), 64'(0));
        tick();
        wm[row] = data;
        check("wr_wl_off", 64'(wl), 64'(0));
        check("wr_bl_held", 64'(bl), 64'(data));
        check("wr_ready_back", 64'(bus.wr_ready), 64'(1));
        check("wr_cell", 64'(cells[row]), 64'(data));
    endtask

    task automatic compute_issue(input logic [ROWS-1:0] x, input int lo, input int hi);
        logic [COLS*SW-1:0] lit, mdl;
        for (int c = 0; c < COLS; c++) lit[c*SW +: SW] = to_slice((c < 4) ? lo : hi);
        mdl = model_res(x);
        check("model_pin", 64'(mdl), 64'(lit));
        wait_idle();
        bus.cmp_valid = 1'b1;
        bus.cmp_x     = x;
        tick();
        bus.cmp_valid = 1'b0;
        exp_res   = mdl;
        exp_armed = 1'b1;
        check("drive_rctrl", 64'(r_ctrl), 64'(x));
        check("drive_wl", 64'(wl), 64'(0));
        check("cmp_busy", 64'(bus.cmp_ready), 64'(0));
        tick();
        check("lat_t1", 64'(bus.res_valid), 64'(0));
        tick();
        check("lat_t2", 64'(bus.res_valid), 64'(0));
        tick();
        check("lat_t3", 64'(bus.res_valid), 64'(1));
        check("result", 64'(bus.res_data), 64'(mdl));
    endtask

    task automatic compute_retire();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        exp_armed = 1'b0;
        check("ret_valid", 64'(bus.res_valid), 64'(0));
        check("ret_rctrl", 64'(r_ctrl), 64'(0));
        check("ret_cmp_ready", 64'(bus.cmp_ready), 64'(1));
    endtask

    initial begin
        logic [ROWS-1:0] ones16;
        ones16 = '1;
        n_vec = 0; n_err = 0; exp_armed = 1'b0; exp_res = '0;
        bus.wr_valid = 1'b0; bus.wr_row = '0; bus.wr_data = '0;
        bus.cmp_valid = 1'b0; bus.cmp_x = '0; bus.res_ready = 1'b0;
        bus2.wr_valid = 1'b0; bus2.wr_row = '0; bus2.wr_data = '0;
        bus2.cmp_valid = 1'b0; bus2.cmp_x = '0; bus2.res_ready = 1'b0;
        for (int r = 0; r < ROWS; r++) wm[r] = '0;
        rst_n = 1'b0; arr_clr = 1'b1;
        repeat (3) tick();
        check("rst_wl", 64'(wl), 64'(0));
        check("rst_bl", 64'(bl), 64'(0));
        check("rst_blb", 64'(blb), 64'(8'hFF));
        check("rst_rctrl", 64'(r_ctrl), 64'(0));
        check("rst_rctrlb", 64'(r_ctrl_b), 64'(ones16));
        check("rst_res_valid", 64'(bus.res_valid), 64'(0));
        check("rst_res_data", 64'(bus.res_data), 64'(0));
        rst_n = 1'b1; arr_clr = 1'b0;
        tick();
        check("rst_wr_ready", 64'(bus.wr_ready), 64'(1));
        check("rst_cmp_ready", 64'(bus.cmp_ready), 64'(1));

        // All-ones weights against all-ones and all-zeros inputs
        for (int r = 0; r < ROWS; r++) do_write(r, 8'hFF);
        compute_issue(16'hFFFF, 16, 16);
        compute_retire();
        compute_issue(16'h0000, 0, 0);
        compute_retire();

        // Split weights select the low or high column half
        for (int r = 0; r < ROWS; r++) do_write(r, (r < 8) ? 8'h0F : 8'hF0);
        compute_issue(16'h00FF, 16, 0);
        compute_retire();

        // Write and compute requested together: write first
        bus.wr_valid = 1'b1; bus.wr_row = RW'(0); bus.wr_data = 8'hF0;
        bus.cmp_valid = 1'b1; bus.cmp_x = 16'h00FF;
        tick();
        bus.wr_valid = 1'b0;
        check("both_wl", 64'(wl), 64'(16'h0001));
        check("both_cmp_wait", 64'(bus.cmp_ready), 64'(0));
        check("both_rctrl", 64'(r_ctrl), 64'(0));
        tick();
        wm[0] = 8'hF0;
        check("both_idle", 64'({bus.wr_ready, bus.cmp_ready}), 64'(2'b11));
        check("both_rctrl2", 64'(r_ctrl), 64'(0));
        compute_issue(16'h00FF, 15, 1);
        compute_retire();

        // Out-of-range row on the 12-row instance
        bus2.wr_valid = 1'b1; bus2.wr_row = 4'd12; bus2.wr_data = 8'hFF;
        tick();
        bus2.wr_valid = 1'b0;
        check("oor_wl", 64'(wl2), 64'(0));
        check("oor_busy", 64'(bus2.wr_ready), 64'(0));
        tick();
        check("oor_wl2", 64'(wl2), 64'(0));
        check("oor_ready", 64'(bus2.wr_ready), 64'(1));
        for (int r = 0; r < R2; r++) check("oor_cell", 64'(cells2[r]), 64'(0));
        bus2.wr_valid = 1'b1; bus2.wr_row = 4'd11; bus2.wr_data = 8'h3C;
        tick();
        bus2.wr_valid = 1'b0;
        check("r11_wl", 64'(wl2), 64'(12'h800));
        tick();
        check("r11_cell", 64'(cells2[11]), 64'(8'h3C));
        check("r11_cell0", 64'(cells2[0]), 64'(0));

        // Backpressure then reset while holding a result
        compute_issue(16'hFFFF, 7, 9);
        repeat (10) begin
            tick();
            check("hold_valid", 64'(bus.res_valid), 64'(1));
            check("hold_cmp_ready", 64'(bus.cmp_ready), 64'(0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_armed = 1'b0;
        check("mid_rst_valid", 64'(bus.res_valid), 64'(0));
        check("mid_rst_data", 64'(bus.res_data), 64'(0));
        check("mid_rst_wl", 64'(wl), 64'(0));
        check("mid_rst_rctrlb", 64'(r_ctrl_b), 64'(ones16));
        check("mid_rst_blb", 64'(blb), 64'(8'hFF));
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 64'({bus.wr_ready, bus.cmp_ready}), 64'(2'b11));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
